imm_load_ctrl: RTL

Sequencer for 16-bit immediate construction in the register-writeback path. Accepts upper-immediate (LHI), lower-immediate (LLI) and direct-load (LDI) requests from decode. Drives the existing `leftshift` datapath (9-bit in, shift by 7, 16-bit out) to place the upper field, merges the lower 7 bits, and presents one register write to writeback over a valid/ready handshake. Also flushes an orphaned upper half after a timeout.

---
 rtl/imm_pkg.sv | 28 ++
 rtl/leftshift.sv | 9 +
 rtl/imm_load_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/imm_pkg.sv
// Shared encodings, widths and helpers for the immediate-load sequencer.
package imm_pkg;

  localparam int IMM_W  = 9;
  localparam int LO_W   = 7;
  localparam int DATA_W = 16;
  localparam int RD_W   = 3;

  typedef enum logic [1:0] {
    OP_LHI   = 2'b00,
    OP_LLI   = 2'b01,
    OP_LDI   = 2'b10,
    OP_FLUSH = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    HAVE_UPPER = 2'b01,
    WB         = 2'b10
  } state_e;

  // Upper field sits in [15:7] and the low field in [6:0], so OR never carries.
  function automatic logic [DATA_W-1:0] merge_lo(input logic [DATA_W-1:0] upper,
                                                 input logic [LO_W-1:0]   lo);
    merge_lo = upper | {{(DATA_W-LO_W){1'b0}}, lo};
  endfunction

endpackage

// File: rtl/leftshift.sv
// Existing datapath block: places a 9-bit immediate in bits [15:7] of a 16-bit word.
module leftshift (
  input  logic [8:0]  in,
  output logic [15:0] out
);

  assign out = {in, 7'b000_0000};

endmodule

// File: rtl/imm_load_ctrl.sv
// Immediate-construction sequencer: LHI/LLI pairing, LDI, FLUSH and orphan timeout.
// Optional build macro IMM_LDI_SEXT_EN: LDI sign-extends req_imm[8] instead of zero-extending.
module imm_load_ctrl
  import imm_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [IMM_W-1:0]  req_imm,
  input  logic [RD_W-1:0]   req_rd,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              err
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_e            state;
  op_e               op;
  logic [DATA_W-1:0] upper;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ldi_data;
  logic [RD_W-1:0]   rd;
  logic [TW-1:0]     timer;
  logic              expire;

  assign op = op_e'(req_op);

  leftshift u_leftshift (
    .in  (req_imm),
    .out (shifted)
  );

`ifdef IMM_LDI_SEXT_EN
  assign ldi_data = {{(DATA_W-IMM_W){req_imm[IMM_W-1]}}, req_imm};
`else
  assign ldi_data = {{(DATA_W-IMM_W){1'b0}}, req_imm};
`endif

  // Expiry fires in the cycle the timer would reach TIMEOUT; TIMEOUT of 0 disables it.
  assign expire = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));

  assign req_ready = (state != WB);
  assign busy      = (state != IDLE);

  // Sequencer state, pending upper half, timer and registered writeback outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      upper    <= '0;
      rd       <= '0;
      timer    <= '0;
      wb_valid <= 1'b0;
      wb_data  <= '0;
      wb_rd    <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            case (op)
              OP_LHI: begin
                upper <= shifted;
                rd    <= req_rd;
                timer <= '0;
                state <= HAVE_UPPER;
              end
              OP_LLI: err <= 1'b1;
              OP_LDI: begin
                wb_data  <= ldi_data;
                wb_rd    <= req_rd;
                wb_valid <= 1'b1;
                state    <= WB;
              end
              default: ;
            endcase
          end
        end
        HAVE_UPPER: begin
          if (req_valid) begin
            case (op)
              OP_LLI: begin
                if (req_rd == rd) begin
                  wb_data  <= merge_lo(upper, req_imm[LO_W-1:0]);
                  wb_rd    <= rd;
                  wb_valid <= 1'b1;
                  state    <= WB;
                end else begin
                  err <= 1'b1;
                end
              end
              OP_LHI: begin
                err   <= 1'b1;
                upper <= shifted;
                rd    <= req_rd;
                timer <= '0;
              end
              OP_LDI: begin
                err      <= 1'b1;
                upper    <= '0;
                wb_data  <= ldi_data;
                wb_rd    <= req_rd;
                wb_valid <= 1'b1;
                state    <= WB;
              end
              default: begin
                upper <= '0;
                state <= IDLE;
              end
            endcase
          end else if (expire) begin
            wb_data  <= upper;
            wb_rd    <= rd;
            wb_valid <= 1'b1;
            state    <= WB;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WB: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
